// File: rtl/step_gen_pkg.sv
// Shared types and constants for the step generator.
// The abort feature is enabled by defining STEP_GEN_ABORT_EN.
package step_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_RETURN = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [1:0] PH_IDLE = 2'b00;
  localparam logic [1:0] PH_UP   = 2'b01;
  localparam logic [1:0] PH_DN   = 2'b10;

  localparam logic [2:0] MAX_POS_DEFAULT = 3'd5;

  // Saturate a requested position to the highest reachable position.
  function automatic logic [2:0] clamp_target(input logic [2:0] t, input logic [2:0] lim);
    return (t > lim) ? lim : t;
  endfunction

endpackage

// File: rtl/step_generator_if.sv
// Command / phase / status bundle for the step generator.
// The abort line exists only when STEP_GEN_ABORT_EN is defined.
interface step_generator_if;
  logic       cmd_valid;
  logic [2:0] cmd_target;
  logic       cmd_ready;
  logic       in3;
  logic       in2;
  logic [2:0] pos;
  logic       available;
  logic       done;
`ifdef STEP_GEN_ABORT_EN
  logic       abort;
`endif

  // Commanding side (issues targets, watches phases and status).
  modport master (
`ifdef STEP_GEN_ABORT_EN
    output abort,
`endif
    output cmd_valid, cmd_target,
    input  cmd_ready, in3, in2, pos, available, done
  );

  // Step generator side.
  modport slave (
`ifdef STEP_GEN_ABORT_EN
    input  abort,
`endif
    input  cmd_valid, cmd_target,
    output cmd_ready, in3, in2, pos, available, done
  );
endinterface

// File: rtl/step_generator_dwell_timer.sv
// Phase hold timer: load sets DWELL-1, then counts down to zero and stays there.
// expire is high on the last cycle of a phase (and whenever the timer is idle).
module dwell_timer #(
  parameter int unsigned DWELL = 4
) (
  input  logic orgclk,
  input  logic rst_n,
  input  logic load,
  output logic expire
);

  localparam logic [7:0] LOAD_VAL = 8'(DWELL - 1);

  logic [7:0] cnt_q, cnt_d;

  // Next count: reload on phase entry, otherwise count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge orgclk) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == 8'd0);

endmodule

// File: rtl/step_generator.sv
// Step generator: walks pos toward a commanded target one step at a time,
// each step a PULSE phase followed by a RETURN (00) phase, DWELL cycles each.
// Optional abort input when STEP_GEN_ABORT_EN is defined.
module step_generator
  import step_gen_pkg::*;
#(
  parameter int unsigned DWELL   = 4,
  parameter logic [2:0]  MAX_POS = MAX_POS_DEFAULT
) (
`ifdef STEP_GEN_ABORT_EN
  input  logic       abort,
`endif
  input  logic       orgclk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_target,
  output logic       cmd_ready,
  output logic       in3,
  output logic       in2,
  output logic [2:0] pos,
  output logic       available,
  output logic       done
);

  state_t     state_q, state_d;
  logic [2:0] pos_q, pos_d;
  logic [2:0] target_q, target_d;
  logic       dir_up_q, dir_up_d;
  logic       load;
  logic       expire;
  logic       stop_req;
  logic [2:0] tgt_clamped;
  logic [1:0] phase;

  dwell_timer #(.DWELL(DWELL)) u_timer (
    .orgclk (orgclk),
    .rst_n  (rst_n),
    .load   (load),
    .expire (expire)
  );

  assign tgt_clamped = clamp_target(cmd_target, MAX_POS);

`ifdef STEP_GEN_ABORT_EN
  logic abort_pend_q, abort_pend_d;

  // Remember an abort seen during a move so the move ends after its RETURN.
  always_comb begin
    abort_pend_d = abort_pend_q;
    if ((state_q == ST_PULSE || state_q == ST_RETURN) && abort) abort_pend_d = 1'b1;
    if (state_q == ST_IDLE || state_q == ST_FINISH)             abort_pend_d = 1'b0;
  end

  // Abort-pending flag register.
  always_ff @(posedge orgclk) begin
    if (!rst_n) abort_pend_q <= 1'b0;
    else        abort_pend_q <= abort_pend_d;
  end

  assign stop_req = abort | abort_pend_q;
`else
  assign stop_req = 1'b0;
`endif

  // Next-state logic: acceptance, step timing, position update.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    target_d = target_q;
    dir_up_d = dir_up_q;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          target_d = tgt_clamped;
          if (tgt_clamped != pos_q) begin
            state_d  = ST_PULSE;
            dir_up_d = (tgt_clamped > pos_q);
            load     = 1'b1;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_PULSE: begin
        // An abort cuts the pulse short but the step still counts.
        if (expire || stop_req) begin
          state_d = ST_RETURN;
          pos_d   = dir_up_q ? pos_q + 3'd1 : pos_q - 3'd1;
          load    = 1'b1;
        end
      end
      ST_RETURN: begin
        if (expire) begin
          if (pos_q != target_q && !stop_req) begin
            state_d  = ST_PULSE;
            dir_up_d = (target_q > pos_q);
            load     = 1'b1;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge orgclk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pos_q    <= 3'd0;
      target_q <= 3'd0;
      dir_up_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      target_q <= target_d;
      dir_up_q <= dir_up_d;
    end
  end

  // Outputs decoded from registered state, so they are clean after reset.
  always_comb begin
    phase = PH_IDLE;
    if (state_q == ST_PULSE) phase = dir_up_q ? PH_UP : PH_DN;
  end

  assign {in3, in2}  = phase;
  assign cmd_ready   = (state_q == ST_IDLE);
  assign done        = (state_q == ST_FINISH);
  assign pos         = pos_q;
  assign available   = (pos_q != MAX_POS);

endmodule

// File: doc/step_generator.md
STEP_GENERATOR -- requirements
Module: step_generator

Interface
REQ-001 SHALL have parameter DWELL, default 4: clock cycles each phase is held; legal range 1..255.
REQ-002 SHALL have parameter MAX_POS, default 3'd5: highest reachable position.
REQ-003 SHALL have port orgclk, input, 1: the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1: a target position is offered.
REQ-006 SHALL have port cmd_target, input, 3: requested absolute position.
REQ-007 SHALL have port cmd_ready, output, 1: block can accept a command.
REQ-008 SHALL have ports in3 and in2, outputs, 1 each: phase pair driven to the motor-position counter.
REQ-009 SHALL have port pos, output, 3: current position after completed steps.
REQ-010 SHALL have port available, output, 1: low when pos == MAX_POS, else high.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when a command finishes.

Function
REQ-012 SHALL accept a command on a cycle where cmd_valid and cmd_ready are both high; cmd_ready SHALL be high only in IDLE.
REQ-013 SHALL clamp cmd_target > MAX_POS to MAX_POS at acceptance and register the clamped value.
REQ-014 SHALL implement FSM states IDLE, PULSE, RETURN, FINISH.
REQ-015 IDLE -> PULSE on acceptance if target != pos; IDLE -> FINISH if target == pos.
REQ-016 PULSE SHALL drive {in3,in2} = 2'b01 when target > pos (up) and 2'b10 when target < pos (down), for exactly DWELL cycles; direction is latched on entry to PULSE.
REQ-017 PULSE -> RETURN after DWELL cycles; on that transition pos SHALL increment (up) or decrement (down) by 1.
REQ-018 RETURN SHALL drive {in3,in2} = 2'b00 for exactly DWELL cycles; then -> PULSE if pos != target, else -> FINISH.
REQ-019 FINISH SHALL assert done for one cycle and go to IDLE; cmd_ready rises the cycle after done.
REQ-020 {in3,in2} SHALL be 2'b00 in IDLE and FINISH; 2'b11 is never driven.
REQ-021 Latency from the acceptance edge to done high SHALL be 2*DWELL*N + 1 cycles, N = |target - pos|; for N = 0, done is high the cycle after acceptance.
REQ-022 pos SHALL stay within 0..MAX_POS; no wrap-around in either direction.
REQ-023 cmd_valid while cmd_ready is low SHALL be ignored; no queuing.
REQ-024 available SHALL be combinational from pos.

Reset
REQ-025 While rst_n is low at a clock edge: state = IDLE, {in3,in2} = 2'b00, pos = 0, done = 0, available = 1, dwell counter = 0.
REQ-026 Reset mid-step SHALL abandon the step without counting it; cmd_ready is high the first cycle after rst_n returns high.

Configuration
REQ-027 With STEP_GEN_ABORT_EN defined, there SHALL be an input port abort, 1 bit.
REQ-028 With STEP_GEN_ABORT_EN defined, abort high in PULSE SHALL end PULSE immediately, count the step, and run a full RETURN before going to FINISH.
REQ-029 With STEP_GEN_ABORT_EN defined, abort high in RETURN SHALL go to FINISH after RETURN completes.
REQ-030 With STEP_GEN_ABORT_EN defined, abort SHALL be ignored in IDLE and FINISH.
REQ-031 Without STEP_GEN_ABORT_EN, the abort port and abort logic SHALL be absent.

Structure
REQ-032 Shared package step_gen_pkg SHALL hold the state enum, phase constants PH_IDLE = 2'b00, PH_UP = 2'b01, PH_DN = 2'b10, and default MAX_POS = 3'd5.
REQ-033 The dwell counter SHALL be a sub-module dwell_timer (load, count down, expire pulse) replacing any clock divider; no derived clocks.

Verification
REQ-034 Reset, then target 3 with DWELL=4 -> phases 01x4, 00x4 repeated 3 times; pos 0->1->2->3; done at cycle 25 after acceptance.
REQ-035 From pos 3, target 1 -> 10/00 pattern twice; pos 3->2->1; done at cycle 17.
REQ-036 Target 7 from pos 0 -> clamped to 5; 5 steps; available falls when pos = 5; done at cycle 41.
REQ-037 Target equal to pos (2->2) -> no phase activity; done the cycle after acceptance; cmd_valid held high during a move causes no second acceptance until cmd_ready.
REQ-038 rst_n low during the 2nd PULSE of a 0->3 move -> next cycle {in3,in2} = 00, pos = 0, cmd_ready = 1.
REQ-039 With STEP_GEN_ABORT_EN defined, abort in the 1st PULSE of a 0->4 move -> pos = 1, one RETURN of 4 cycles, then done.
